// File: rtl/sr_pkg.sv
// ----------------------------------------------------------------------------
// sr_pkg
// Definitions shared by the serial write/readback engine and its clock
// generator:
//   - sr_state_t : one-hot FSM state encoding (IDLE/SHIFT/LOAD/DONE)
//   - sr_clog2   : ceiling log2, used for elaboration-time width checks and
//                  for sizing small internal counters
// ----------------------------------------------------------------------------
package sr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_LOAD  = 4'b0100,
        ST_DONE  = 4'b1000
    } sr_state_t;

    // Ceiling log2; sr_clog2(1) = 0, sr_clog2(2) = 1, sr_clog2(171) = 8.
    function automatic int sr_clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sr_clk_gen.sv
// ----------------------------------------------------------------------------
// sr_clk_gen
// Divided serial clock for the shift-register engine. While en is high a
// half-period counter runs from 0 to div and toggles sclk each time it hits
// div, so each sclk phase lasts div+1 clk cycles. The counter compares before
// incrementing, so div = all-ones never wraps it. While en is low sclk idles
// low and the counter is held at zero, so the first phase after enable is a
// full low phase.
// Ports:
//   clk, rst : control clock, asynchronous active-high reset
//   en       : run the divider
//   div      : half-period minus one
//   sclk     : registered serial clock
//   rise     : this clk edge drives sclk 0->1
//   fall     : this clk edge drives sclk 1->0
// ----------------------------------------------------------------------------
module sr_clk_gen
    import sr_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 sclk,
    output logic                 rise,
    output logic                 fall
);

    logic [DIV_WIDTH-1:0] half_cnt_r;
    logic                 sclk_r;
    logic                 half_end_s;

    assign half_end_s = (half_cnt_r == div);

    // Half-period counter and sclk toggle flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt_r <= '0;
            sclk_r     <= 1'b0;
        end else if (!en) begin
            half_cnt_r <= '0;
            sclk_r     <= 1'b0;
        end else if (half_end_s) begin
            half_cnt_r <= '0;
            sclk_r     <= ~sclk_r;
        end else begin
            half_cnt_r <= half_cnt_r + DIV_WIDTH'(1);
        end
    end

    assign rise = en & half_end_s & ~sclk_r;
    assign fall = en & half_end_s & sclk_r;
    assign sclk = sclk_r;

endmodule

// File: rtl/sr_rw_engine.sv
// ----------------------------------------------------------------------------
// sr_rw_engine
// Serial write/readback engine for configuration shift-register chains.
// On an accepted start the word din is shifted out on sdo under a divided
// serial clock, the bits returned on sdi are captured into dout_rb, and
// load_sr is pulsed for LOAD_CYCLES clk cycles, followed by a one-cycle done.
// Ports:
//   clk, rst : control clock, asynchronous active-high reset
//   start    : request, accepted only in IDLE (din/div latched on accept)
//   din      : word to write
//   div      : sclk half-period minus one
//   sdi      : serial return from the end of the chain
//   busy     : high from the cycle after accept through the done cycle
//   done     : one-cycle completion pulse, dout_rb valid from this cycle
//   dout_rb  : captured readback word, cleared on accept
//   sdo      : serial data to the chain
//   sclk     : serial clock, idles low
//   load_sr  : parallel-load strobe to the chain
//   bit_cnt  : number of bits completed in the current transfer
// All outputs come straight from flops (sclk from the divider's flop).
// ----------------------------------------------------------------------------
module sr_rw_engine
    import sr_pkg::*;
#(
    parameter int DATA_WIDTH      = 170,
    parameter int CNT_WIDTH       = 8,
    parameter int DIV_WIDTH       = 8,
    parameter int SHIFT_DIRECTION = 1,
    parameter int LOAD_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  sdi,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout_rb,
    output logic                  sdo,
    output logic                  sclk,
    output logic                  load_sr,
    output logic [CNT_WIDTH-1:0]  bit_cnt
);

    localparam int LOAD_CNT_W = (sr_clog2(LOAD_CYCLES) < 1) ? 1 : sr_clog2(LOAD_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  LAST_BIT  = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [LOAD_CNT_W-1:0] LOAD_LAST = LOAD_CNT_W'(LOAD_CYCLES - 1);

    generate
        if (CNT_WIDTH < sr_clog2(DATA_WIDTH + 1)) begin : g_cnt_width_check
            $error("sr_rw_engine: CNT_WIDTH cannot hold DATA_WIDTH");
        end
    endgenerate

    sr_state_t                 state_r;
    sr_state_t                 state_nxt_s;
    logic [DATA_WIDTH-1:0]     sh_r;
    logic [DATA_WIDTH-1:0]     rb_r;
    logic [DATA_WIDTH-1:0]     sh_shift_s;
    logic [DATA_WIDTH-1:0]     rb_shift_s;
    logic [DATA_WIDTH-1:0]     sdi_lsb_s;
    logic [DATA_WIDTH-1:0]     sdi_msb_s;
    logic [DIV_WIDTH-1:0]      div_l_r;
    logic [CNT_WIDTH-1:0]      bit_cnt_r;
    logic [LOAD_CNT_W-1:0]     load_cnt_r;
    logic                      sdo_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      load_sr_r;
    logic                      accept_s;
    logic                      sclk_s;
    logic                      rise_s;
    logic                      fall_s;

    // Bit that goes on the wire first from a word, for the configured order.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] word);
        if (SHIFT_DIRECTION != 0) begin
            return word[DATA_WIDTH-1];
        end else begin
            return word[0];
        end
    endfunction

    sr_clk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_r == ST_SHIFT),
        .div  (div_l_r),
        .sclk (sclk_s),
        .rise (rise_s),
        .fall (fall_s)
    );

    assign accept_s = (state_r == ST_IDLE) & start;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; SHIFT ends on the falling sclk of the last bit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_SHIFT;
                else       state_nxt_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (fall_s && (bit_cnt_r == LAST_BIT)) state_nxt_s = ST_LOAD;
                else                                   state_nxt_s = ST_SHIFT;
            end
            ST_LOAD: begin
                if (load_cnt_r == LOAD_LAST) state_nxt_s = ST_DONE;
                else                         state_nxt_s = ST_LOAD;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next contents of the transmit and readback shifters.
    always_comb begin
        sdi_lsb_s                 = '0;
        sdi_msb_s                 = '0;
        sdi_lsb_s[0]              = sdi;
        sdi_msb_s[DATA_WIDTH-1]   = sdi;
        if (SHIFT_DIRECTION != 0) begin
            sh_shift_s = sh_r << 1'b1;
            rb_shift_s = (rb_r << 1'b1) | sdi_lsb_s;
        end else begin
            sh_shift_s = sh_r >> 1'b1;
            rb_shift_s = (rb_r >> 1'b1) | sdi_msb_s;
        end
    end

    // Datapath: latch on accept, sample sdi on sclk rise, advance on sclk fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r      <= '0;
            rb_r      <= '0;
            div_l_r   <= '0;
            bit_cnt_r <= '0;
            sdo_r     <= 1'b0;
        end else if (accept_s) begin
            sh_r      <= din;
            rb_r      <= '0;
            div_l_r   <= div;
            bit_cnt_r <= '0;
            sdo_r     <= first_bit(din);
        end else if (state_r == ST_SHIFT) begin
            if (rise_s) begin
                rb_r <= rb_shift_s;
            end
            if (fall_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_WIDTH'(1);
                if (bit_cnt_r == LAST_BIT) begin
                    sdo_r <= 1'b0;
                end else begin
                    sh_r  <= sh_shift_s;
                    sdo_r <= first_bit(sh_shift_s);
                end
            end
        end
    end

    // Load-pulse length counter; runs only while in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_r <= '0;
        end else if (state_r == ST_LOAD) begin
            load_cnt_r <= load_cnt_r + LOAD_CNT_W'(1);
        end else begin
            load_cnt_r <= '0;
        end
    end

    // Handshake/strobe flops decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            load_sr_r <= 1'b0;
        end else begin
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
            load_sr_r <= (state_nxt_s == ST_LOAD);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign load_sr = load_sr_r;
    assign sdo     = sdo_r;
    assign sclk    = sclk_s;
    assign dout_rb = rb_r;
    assign bit_cnt = bit_cnt_r;

endmodule

// File: tb/tb_sr_rw_engine.sv
// ----------------------------------------------------------------------------
// tb_sr_rw_engine
// Directed bench for sr_rw_engine. Four instances cover the configurations:
//   A: W=170 MSB-first, loopback (sdi = sdo)
//   B: W=8   LSB-first, loopback
//   C: W=8   MSB-first, chain model returning sdo one sclk late
//   D: W=1   MSB-first, loopback
// Cycle numbering: the cycle in which start is sampled is cycle 0; the value
// seen just after the k-th clk edge (accept edge = 1st) is cycle k.
// ----------------------------------------------------------------------------
module tb_sr_rw_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A
    logic         a_start = 1'b0;
    logic [169:0] a_din   = '0;
    logic [7:0]   a_div   = 8'd0;
    logic         a_busy, a_done, a_sdo, a_sclk, a_load;
    logic [169:0] a_dout;
    logic [7:0]   a_cnt;
    // Instance B
    logic         b_start = 1'b0;
    logic [7:0]   b_din   = 8'd0;
    logic [7:0]   b_div   = 8'd0;
    logic         b_busy, b_done, b_sdo, b_sclk, b_load;
    logic [7:0]   b_dout;
    logic [3:0]   b_cnt;
    // Instance C
    logic         c_start = 1'b0;
    logic [7:0]   c_din   = 8'd0;
    logic [7:0]   c_div   = 8'd0;
    logic         c_busy, c_done, c_sdo, c_sclk, c_load, c_sdi;
    logic [7:0]   c_dout;
    logic [3:0]   c_cnt;
    logic         c_q = 1'b0;
    // Instance D
    logic         d_start = 1'b0;
    logic [0:0]   d_din   = 1'b0;
    logic [7:0]   d_div   = 8'd0;
    logic         d_busy, d_done, d_sdo, d_sclk, d_load;
    logic [0:0]   d_dout;
    logic [0:0]   d_cnt;

    sr_rw_engine #(.DATA_WIDTH(170), .CNT_WIDTH(8), .DIV_WIDTH(8), .SHIFT_DIRECTION(1), .LOAD_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .din(a_din), .div(a_div), .sdi(a_sdo),
        .busy(a_busy), .done(a_done), .dout_rb(a_dout), .sdo(a_sdo), .sclk(a_sclk),
        .load_sr(a_load), .bit_cnt(a_cnt));

    sr_rw_engine #(.DATA_WIDTH(8), .CNT_WIDTH(4), .DIV_WIDTH(8), .SHIFT_DIRECTION(0), .LOAD_CYCLES(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .din(b_din), .div(b_div), .sdi(b_sdo),
        .busy(b_busy), .done(b_done), .dout_rb(b_dout), .sdo(b_sdo), .sclk(b_sclk),
        .load_sr(b_load), .bit_cnt(b_cnt));

    sr_rw_engine #(.DATA_WIDTH(8), .CNT_WIDTH(4), .DIV_WIDTH(8), .SHIFT_DIRECTION(1), .LOAD_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .din(c_din), .div(c_div), .sdi(c_sdi),
        .busy(c_busy), .done(c_done), .dout_rb(c_dout), .sdo(c_sdo), .sclk(c_sclk),
        .load_sr(c_load), .bit_cnt(c_cnt));

    sr_rw_engine #(.DATA_WIDTH(1), .CNT_WIDTH(1), .DIV_WIDTH(8), .SHIFT_DIRECTION(1), .LOAD_CYCLES(2)) u_d (
        .clk(clk), .rst(rst), .start(d_start), .din(d_din), .div(d_div), .sdi(d_sdo),
        .busy(d_busy), .done(d_done), .dout_rb(d_dout), .sdo(d_sdo), .sclk(d_sclk),
        .load_sr(d_load), .bit_cnt(d_cnt));

    // One-stage chain model for C: sdo is captured on each sclk rise and
    // returned on sdi, so the engine sees every bit one sclk late.
    always @(posedge c_sclk or posedge rst) begin
        if (rst) c_q <= 1'b0;
        else     c_q <= c_sdo;
    end
    assign c_sdi = c_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a div=0 transfer on A and wait for done; lat is the done cycle.
    task automatic a_run(input logic [169:0] d, output int lat, output int loads);
        a_din   = d;
        a_div   = 8'd0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        lat     = 1;
        loads   = 0;
        while (!a_done && lat < 1000) begin
            if (a_load) loads++;
            step();
            lat++;
        end
    endtask

    initial begin
        logic [191:0] rnd;
        logic [169:0] word;
        logic [169:0] saved;
        logic [7:0]   sent;
        int           n, loads, k, dones, done_n, high_total, rise0, rise1, first_hi, fall_n;
        logic         prev, p3, p100;

        // Reset state
        #1;
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_outs", {a_done, a_sdo, a_sclk, a_load}, 4'b0000);
        chk("rst_a_cnt",  a_cnt, 8'd0);
        chk("rst_a_dout", a_dout, 170'd0);
        chk("rst_bcd",    {b_busy, c_busy, d_busy, b_sclk, c_sclk, d_sclk}, 6'b000000);
        step();
        step();
        rst = 1'b0;
        step();

        // T1: MSB-first loopback, W=170, div=0
        rnd  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        word = rnd[169:0];
        a_run(word, n, loads);
        chk("t1_latency", n, 343);
        chk("t1_dout",    a_dout, word);
        chk("t1_load_len", loads, 2);
        chk("t1_bitcnt",  a_cnt, 8'd170);
        chk("t1_busy_in_done", a_busy, 1'b1);
        step();
        chk("t1_done_pulse", a_done, 1'b0);
        chk("t1_busy_after", a_busy, 1'b0);

        // T2: LSB-first, 8'hA5, div=3 -> sclk period 8, 4 high / 4 low
        b_din = 8'hA5; b_div = 8'd3; b_start = 1'b1;
        step();
        b_start = 1'b0;
        n = 1; k = 0; high_total = 0; rise0 = 0; rise1 = 0; prev = 1'b0; sent = 8'd0;
        while (!b_done && n < 300) begin
            if (b_sclk && !prev) begin
                if (k < 8) sent[k] = b_sdo;
                if (k == 0) rise0 = n;
                if (k == 1) rise1 = n;
                k++;
            end
            if (b_sclk) high_total++;
            prev = b_sclk;
            step();
            n++;
        end
        chk("t2_sdo_order", sent, 8'hA5);
        chk("t2_first_rise", rise0, 5);
        chk("t2_period", rise1 - rise0, 8);
        chk("t2_high_cycles", high_total, 32);
        chk("t2_latency", n, 67);
        chk("t2_dout", b_dout, 8'hA5);

        // T3: chain delayed by one sclk, MSB-first 8'hF0, div=1.
        // Sampled sequence 0,1,1,1,1,0,0,0 -> 8'h78.
        c_din = 8'hF0; c_div = 8'd1; c_start = 1'b1;
        step();
        c_start = 1'b0;
        n = 1;
        while (!c_done && n < 300) begin
            step();
            n++;
        end
        chk("t3_latency", n, 35);
        chk("t3_dout", c_dout, 8'h78);

        // T4: start pulses at bits 3 and 100, din/div changed mid-transfer
        rnd   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        saved = rnd[169:0];
        a_din = saved; a_div = 8'd0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 1; dones = 0; done_n = 0; p3 = 1'b0; p100 = 1'b0;
        while (n < 420) begin
            if (a_cnt == 8'd3 && !p3) begin
                a_start = 1'b1; p3 = 1'b1; a_din = ~saved; a_div = 8'd9;
            end else if (a_cnt == 8'd100 && !p100) begin
                a_start = 1'b1; p100 = 1'b1;
            end else begin
                a_start = 1'b0;
            end
            if (a_done) begin
                dones++;
                if (dones == 1) done_n = n;
            end
            step();
            n++;
        end
        chk("t4_done_count", dones, 1);
        chk("t4_latency", done_n, 343);
        chk("t4_dout", a_dout, saved);
        chk("t4_idle", a_busy, 1'b0);

        // T6: W=1, div=255, start held high across completion
        d_din = 1'b1; d_div = 8'hFF; d_start = 1'b1;
        step();
        n = 1; first_hi = 0; fall_n = 0;
        while (!d_done && n < 1000) begin
            if (d_sclk && first_hi == 0) first_hi = n;
            if (!d_sclk && first_hi != 0 && fall_n == 0) fall_n = n;
            step();
            n++;
        end
        chk("t6_first_high", first_hi, 257);
        chk("t6_fall", fall_n, 513);
        chk("t6_latency", n, 515);
        chk("t6_dout", d_dout, 1'b1);
        chk("t6_bitcnt", d_cnt, 1'b1);
        step();
        chk("t6_idle_gap", {d_busy, d_done}, 2'b00);
        step();
        chk("t6_retrigger", d_busy, 1'b1);
        d_start = 1'b0;

        // T5: reset at bit 50, then a clean transfer
        rnd  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        word = rnd[169:0] | 170'd1;
        a_din = word; a_div = 8'd0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 1;
        while (a_cnt != 8'd50 && n < 500) begin
            step();
            n++;
        end
        chk("t5_reach50", a_cnt, 8'd50);
        rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", {a_busy, a_done, a_sdo, a_sclk, a_load}, 5'b00000);
        chk("t5_rst_cnt", a_cnt, 8'd0);
        chk("t5_rst_dout", a_dout, 170'd0);
        chk("t5_rst_d", d_busy, 1'b0);
        rst = 1'b0;
        step();
        step();
        chk("t5_no_resume", a_busy, 1'b0);
        rnd  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        word = rnd[169:0];
        a_run(word, n, loads);
        chk("t5_latency", n, 343);
        chk("t5_dout", a_dout, word);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
